// File: rtl/kgp_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory req/ack, branch redirect, decode valid/ready.
// master = fetch unit side, slave = memory/branch/decode environment side.
interface kgp_fetch_unit_if #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 4
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  logic            redir_valid;
  logic [1:0]      redir_type;
  logic [XLEN-1:0] redir_pc;
  logic [25:0]     redir_imm;
  logic [XLEN-1:0] redir_reg;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   buf_count;
  logic            misalign_trap;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redir_valid, redir_type, redir_pc, redir_imm, redir_reg,
    output out_valid, out_instr, out_pc, buf_count, misalign_trap,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redir_valid, redir_type, redir_pc, redir_imm, redir_reg,
    input  out_valid, out_instr, out_pc, buf_count, misalign_trap,
    output out_ready
  );
endinterface

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC instruction fetch front end: sequential fetch, prefetch FIFO, redirect targets.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect target raises a one-cycle
// misalign_trap and halts fetch until an aligned redirect; otherwise target[1:0] is cleared.
module kgp_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  kgp_fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, FULL, DISCARD, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, FULL, DISCARD} state_t;
`endif

  state_t          state, stateNext;
  logic [XLEN-1:0] fetchPc, fetchPcNext;
  logic [XLEN-1:0] savedPc, savedPcNext;

  logic [31:0]     memInstr [BUF_DEPTH];
  logic [XLEN-1:0] memPc    [BUF_DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count, countNext;
  logic [31:0]     lastInstr;
  logic [XLEN-1:0] lastPc;

  logic            req, push, pop, redir, outValid;
  logic [XLEN-1:0] p4, rawTarget, target;

  // Redirect target for the three branch flavours; all arithmetic wraps mod 2^XLEN.
  always_comb begin
    p4 = bus.redir_pc + XLEN'(4);
    case (bus.redir_type)
      2'b00:   rawTarget = p4 + {{(XLEN-23){bus.redir_imm[20]}}, bus.redir_imm[20:0], 2'b00};
      2'b01:   rawTarget = {p4[XLEN-1:28], bus.redir_imm, 2'b00};
      default: rawTarget = bus.redir_reg;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned, haltPending, haltPendingNext, trapQ;
  assign misaligned = |rawTarget[1:0];
  assign target     = rawTarget;
`else
  assign target     = rawTarget & ~XLEN'(3);
`endif

  // Request is gated by reset so the first request appears once rst is low.
  assign req      = !rst && ((state == FETCH && count < CW'(BUF_DEPTH)) || state == DISCARD);
  assign redir    = bus.redir_valid;
  assign outValid = (count != '0);
  assign push     = req && bus.imem_ack && state == FETCH && !redir;
  assign pop      = outValid && bus.out_ready && !redir;

  // Occupancy after this edge; a redirect flushes everything.
  always_comb begin
    countNext = count;
    if (redir)
      countNext = '0;
    else if (push && !pop)
      countNext = count + CW'(1);
    else if (pop && !push)
      countNext = count - CW'(1);
  end

  // Next fetch state; redirect outranks everything else.
  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    savedPcNext = savedPc;
`ifdef FETCH_ALIGN_CHECK_EN
    haltPendingNext = haltPending;
`endif
    if (redir) begin
      if (req && !bus.imem_ack) begin
        // Outstanding request must finish at the old address; remember where to go.
        stateNext   = DISCARD;
        savedPcNext = target;
`ifdef FETCH_ALIGN_CHECK_EN
        haltPendingNext = misaligned;
      end else if (misaligned) begin
        stateNext = HALT;
`endif
      end else begin
        stateNext   = FETCH;
        fetchPcNext = target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (push) fetchPcNext = fetchPc + XLEN'(4);
          if (countNext == CW'(BUF_DEPTH)) stateNext = FULL;
        end
        FULL:
          if (pop) stateNext = FETCH;
        DISCARD:
          if (bus.imem_ack) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (haltPending) stateNext = HALT;
            else begin
              stateNext   = FETCH;
              fetchPcNext = savedPc;
            end
`else
            stateNext   = FETCH;
            fetchPcNext = savedPc;
`endif
          end
        default: ;
      endcase
    end
  end

  // State and fetch address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      fetchPc <= RESET_PC;
      savedPc <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      savedPc <= savedPcNext;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Trap pulse and deferred-halt flag for misaligned targets.
  always_ff @(posedge clk) begin
    if (rst) begin
      trapQ       <= 1'b0;
      haltPending <= 1'b0;
    end else begin
      trapQ       <= redir && misaligned;
      haltPending <= haltPendingNext;
    end
  end
  assign bus.misalign_trap = trapQ;
`else
  assign bus.misalign_trap = 1'b0;
`endif

  // FIFO storage; no reset needed, reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      memInstr[wrPtr] <= bus.imem_rdata;
      memPc[wrPtr]    <= fetchPc;
    end
  end

  // FIFO pointers, occupancy and the held head value shown while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      lastInstr <= '0;
      lastPc    <= '0;
    end else begin
      count <= countNext;
      if (outValid) begin
        lastInstr <= memInstr[rdPtr];
        lastPc    <= memPc[rdPtr];
      end
      if (redir) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
      end
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetchPc;
  assign bus.out_valid = outValid;
  assign bus.out_instr = outValid ? memInstr[rdPtr] : lastInstr;
  assign bus.out_pc    = outValid ? memPc[rdPtr]    : lastPc;
  assign bus.buf_count = count;
endmodule
